// File: rtl/dff_write_arbiter.sv
// rtl/dff_write_arbiter.sv - round-robin write arbiter committing one requester's word into a shared register
module dff_write_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NREQ-1:0]                 req,
    input  logic [NREQ*W-1:0]               wdata,
    output logic [NREQ-1:0]                 gnt,
    output logic [$clog2(NREQ)-1:0]         owner,
    output logic [W-1:0]                    q,
    output logic                            q_valid,
    output logic [7:0]                      wr_cnt
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   idx;

    // Scan from the highest offset down so the requester closest to ptr wins.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            gidx    <= '0;
            gnt     <= '0;
            owner   <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            wr_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    q_valid <= 1'b0;
                    if (|req) begin
                        gnt   <= NREQ'(1) << pick;
                        gidx  <= pick;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    // Commit is unconditional: the grant already guaranteed this slot.
                    q       <= wdata[int'(gidx)*W +: W];
                    owner   <= gidx;
                    wr_cnt  <= wr_cnt + 8'd1;
                    ptr     <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
                    gnt     <= '0;
                    q_valid <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
